// File: rtl/hilo_seq_pkg.sv
// Shared types and constants for the HI/LO mult/div sequencer.
package hilo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/hilo_watchdog.sv
// WAIT-state watchdog: counts cycles without the selected unit's done and
// flags expiry on the last permitted cycle.
module hilo_watchdog #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hilo_seq.sv
// HI/LO sequencer: dispatches one mult/div op, waits for the selected unit
// and writes HI/LO. Optional watchdog abort via `HILO_SEQ_TIMEOUT_EN.
module hilo_seq
  import hilo_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic op_start,
  input  logic op_sel,
  input  logic divisor_zero,
  input  logic mult_done,
  input  logic div_done,
  output logic mult_start,
  output logic div_start,
  output logic hilo_sel,
  output logic hi_w,
  output logic lo_w,
  output logic busy,
  output logic done,
  output logic div0_exc,
  output logic timeout
);

  state_t state;
  logic   sel_done;
  logic   expire;

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_chk
    $error("hilo_seq: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  // Only the unit that was actually started may end the wait.
  assign sel_done = (hilo_sel == OP_DIV) ? div_done : mult_done;

`ifdef HILO_SEQ_TIMEOUT_EN
  hilo_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (state == START),
    .enable(state == WAIT && !sel_done),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout <= 1'b0;
    else        timeout <= (state == WAIT) && !sel_done && expire;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hilo_sel   <= OP_MULT;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_w       <= 1'b0;
      lo_w       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_w       <= 1'b0;
      lo_w       <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
      case (state)
        IDLE: if (op_start) begin
          hilo_sel <= op_sel;
          busy     <= 1'b1;
          if (op_sel == OP_DIV && divisor_zero) begin
            state    <= EXC;
            div0_exc <= 1'b1;
          end else begin
            state      <= START;
            mult_start <= (op_sel == OP_MULT);
            div_start  <= (op_sel == OP_DIV);
          end
        end
        START: state <= WAIT;
        WAIT: begin
          // Done wins over a simultaneous watchdog expiry.
          if (sel_done) begin
            state <= WRITE;
            hi_w  <= 1'b1;
            lo_w  <= 1'b1;
            done  <= 1'b1;
          end else if (expire) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_seq.sv
// Scoreboard bench for hilo_seq: driver pushes expected start/result events,
// a negedge monitor pops and compares them as the DUT presents pulses.
module tb_hilo_seq;

  localparam int TO = 40;

  logic clk, reset, op_start, op_sel, divisor_zero, mult_done, div_done;
  logic mult_start, div_start, hilo_sel, hi_w, lo_w, busy, done, div0_exc, timeout;

  hilo_seq #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .divisor_zero(divisor_zero), .mult_done(mult_done), .div_done(div_done),
    .mult_start(mult_start), .div_start(div_start), .hilo_sel(hilo_sel),
    .hi_w(hi_w), .lo_w(lo_w), .busy(busy), .done(done),
    .div0_exc(div0_exc), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic wr;
    logic exc;
    logic tmo;
    logic sel;
  } evt_t;

  evt_t evt_q[$];
  logic start_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse with no expected entry at %0t", name, $time);
  endtask

  // Monitor: every pulse the DUT shows must match the next expected entry.
  always @(negedge clk) begin
    evt_t cur, e;
    logic s;
    if (reset) begin
      if (mult_start || div_start) begin
        if (start_q.size() == 0) unexpected("start_pulse");
        else begin
          s = start_q.pop_front();
          check("start_unit", int'({mult_start, div_start}), s ? 2 - 1 : 2);
        end
      end
      if (done || div0_exc || timeout) begin
        cur = '{wr: done, exc: div0_exc, tmo: timeout, sel: hilo_sel};
        if (evt_q.size() == 0) unexpected("result_event");
        else begin
          e = evt_q.pop_front();
          check("result_event", int'(cur), int'(e));
        end
      end
      if (hi_w || lo_w) check("hi_lo_w_with_done", int'({hi_w, lo_w}), done ? 3 : 0);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_before_op", int'(busy), 0);
  endtask

  // Reference behaviour: divide-by-zero -> exception; WAIT longer than the
  // watchdog limit (when built in) -> timeout; anything else -> HI/LO write.
  task automatic run_op(input logic sel, input logic dz, input int lat,
                        input int noise, input bit glitch);
    evt_t e;
    bit   tmo_case;
    int   last;
    wait_idle();
    tmo_case = 1'b0;
`ifdef HILO_SEQ_TIMEOUT_EN
    tmo_case = !(sel && dz) && (lat > TO);
`endif
    if (sel && dz) e = '{wr: 1'b0, exc: 1'b1, tmo: 1'b0, sel: sel};
    else begin
      start_q.push_back(sel);
      e = tmo_case ? '{wr: 1'b0, exc: 1'b0, tmo: 1'b1, sel: sel}
                   : '{wr: 1'b1, exc: 1'b0, tmo: 1'b0, sel: sel};
    end
    evt_q.push_back(e);
    op_start = 1'b1; op_sel = sel; divisor_zero = dz;
    @(posedge clk); #1;
    op_start = 1'b0; op_sel = 1'($urandom); divisor_zero = 1'($urandom);
    check("accept_busy", int'(busy), 1);
    check("hilo_sel_latch", int'(hilo_sel), int'(sel));
    if (sel && dz) begin
      check("exc_pulse", int'(div0_exc), 1);
      check("exc_no_start", int'({mult_start, div_start}), 0);
      @(posedge clk); #1;
      check("exc_then_idle", int'({busy, div0_exc, hi_w}), 0);
      return;
    end
    check("start_latency", int'({mult_start, div_start}), sel ? 1 : 2);
    if (glitch) begin
      if (sel) div_done = 1'b1; else mult_done = 1'b1;
    end
    last = tmo_case ? TO : lat;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      mult_done = 1'b0; div_done = 1'b0; op_start = 1'b0;
      if (k == 1) check("start_one_cycle", int'({mult_start, div_start}), 0);
      if (k == lat && !tmo_case) begin
        if (sel) div_done = 1'b1; else mult_done = 1'b1;
      end else if (noise != 0) begin
        if (sel) mult_done = (noise == 2) ? 1'b1 : 1'($urandom);
        else     div_done  = (noise == 2) ? 1'b1 : 1'($urandom);
        op_start = (noise == 2) ? 1'b1 : 1'($urandom);
      end
    end
    @(posedge clk); #1;
    mult_done = 1'b0; div_done = 1'b0; op_start = 1'b0;
    if (tmo_case) begin
      check("timeout_pulse", int'(timeout), 1);
      check("timeout_no_write", int'({hi_w, lo_w, done}), 0);
      check("timeout_idle", int'(busy), 0);
    end else begin
      check("write_latency", int'({hi_w, lo_w, done}), 7);
      check("write_busy", int'(busy), 1);
      @(posedge clk); #1;
      check("idle_after_write", int'({busy, hi_w, done}), 0);
      check("hilo_sel_hold", int'(hilo_sel), int'(sel));
    end
  endtask

  task automatic reset_mid_wait();
    wait_idle();
    start_q.push_back(1'b1);
    op_start = 1'b1; op_sel = 1'b1; divisor_zero = 1'b0;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_outs",
          int'({hilo_sel, mult_start, div_start, hi_w, lo_w, done, div0_exc, timeout}), 0);
    evt_q.delete();
    start_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    div_done = 1'b1;
    @(posedge clk); #1;
    div_done = 1'b0;
    check("no_write_after_reset", int'({hi_w, busy}), 0);
    repeat (3) @(posedge clk);
    #1;
    check("still_idle_after_reset", int'({hi_w, busy}), 0);
  endtask

  initial begin
    reset = 1'b0; op_start = 1'b0; op_sel = 1'b0; divisor_zero = 1'b0;
    mult_done = 1'b0; div_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          int'({busy, hilo_sel, mult_start, div_start, hi_w, lo_w, done, div0_exc, timeout}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 1'b0, 33, 0, 1'b0);   // MULT, done 33 cycles after start
    run_op(1'b1, 1'b1, 0,  0, 1'b0);   // DIV by zero
    run_op(1'b0, 1'b1, 4,  0, 1'b0);   // MULT ignores divisor_zero
    run_op(1'b1, 1'b0, 5,  2, 1'b0);   // DIV with mult_done + op_start in WAIT
    run_op(1'b0, 1'b0, 6,  2, 1'b0);   // MULT with div_done + op_start in WAIT
    run_op(1'b1, 1'b0, 1,  0, 1'b1);   // minimum occupancy, done in START
`ifdef HILO_SEQ_TIMEOUT_EN
    run_op(1'b0, 1'b0, TO + 1, 1, 1'b0);  // no done in 40 WAIT cycles
    run_op(1'b1, 1'b0, TO,     1, 1'b0);  // done on the threshold cycle
`else
    run_op(1'b1, 1'b0, TO + 30, 1, 1'b0); // WAIT holds past any limit
`endif
    for (int n = 0; n < 30; n++) begin
      run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(1, TO + 6)), 1, 1'($urandom_range(0, 1)));
    end
    reset_mid_wait();
    run_op(1'b0, 1'b0, 3, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("events_drained", evt_q.size() + start_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
